// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment scanner.
// Segment patterns are active-low {g,f,e,d,c,b,a}; anodes are active-low.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   localparam logic [3:0] AN_OFF   = 4'b1111;

   typedef enum logic {
      PH_BLANK,
      PH_ON
   } slot_ph_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit decoder: 4-bit value to active-low segment pattern.
// Ports: val (digit value in), seg (pattern out, dash for values above 9).
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] val,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      unique case (val)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan.sv
// Four-digit multiplexed common-anode display driver for a mm:ss counter pair.
// Ports: CLK, RESET (sync, active-low), ENABLE, SEC10/SEC6/MIN10/MIN6 digits,
// BLINK per-digit, LZB; outputs SEG, DP, AN (all active-low), FRAME pulse.
module seg7_scan
   import seg7_pkg::*;
#(
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_DIV = 250
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic [3:0] SEC10,
   input  logic [2:0] SEC6,
   input  logic [3:0] MIN10,
   input  logic [2:0] MIN6,
   input  logic [3:0] BLINK,
   input  logic       LZB,
   output logic [6:0] SEG,
   output logic       DP,
   output logic [3:0] AN,
   output logic       FRAME
);

   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   // slot/dig name the position whose outputs are produced at the next edge
   logic [SW-1:0]   slot, slot_n;
   logic [1:0]      dig, dig_n;
   logic [FW-1:0]   fcnt, fcnt_n;
   logic            phase, phase_n;
   logic [3:0][3:0] shd, shd_n;

   logic [6:0]      seg_n;
   logic            dp_n;
   logic [3:0]      an_n;
   logic            frame_n;

   slot_ph_t        ph;
   logic            vis;
   logic [6:0]      dec;

   seg7_decode u_dec (
      .val (shd[dig]),
      .seg (dec)
   );

   always_comb begin
      slot_n  = slot;
      dig_n   = dig;
      fcnt_n  = fcnt;
      phase_n = phase;
      shd_n   = shd;
      an_n    = AN_OFF;
      seg_n   = SEG_OFF;
      dp_n    = 1'b1;

      frame_n = (slot == '0) && (dig == 2'd0);
      if (frame_n)
         shd_n = {{1'b0, MIN6}, MIN10, {1'b0, SEC6}, SEC10};

      if (slot == SW'(SCAN_DIV - 1)) begin
         slot_n = '0;
         dig_n  = dig + 2'd1;
         // blink bookkeeping at the frame boundary
         if (dig == 2'd3) begin
            if (fcnt == FW'(BLINK_DIV - 1)) begin
               fcnt_n  = '0;
               phase_n = ~phase;
            end else begin
               fcnt_n  = fcnt + FW'(1);
            end
         end
      end else begin
         slot_n = slot + SW'(1);
      end

      ph  = (slot < SW'(BLANK_CYC)) ? PH_BLANK : PH_ON;
      vis = ENABLE && (ph == PH_ON)
            && !(BLINK[dig] && !phase)
            && !((dig == 2'd3) && LZB && (shd[3] == 4'd0));

      if (vis) begin
         an_n  = ~(4'b0001 << dig);
         seg_n = dec;
      end
      if (ENABLE && (ph == PH_ON) && (dig == 2'd2) && phase)
         dp_n = 1'b0;
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         slot  <= '0;
         dig   <= 2'd0;
         fcnt  <= '0;
         phase <= 1'b1;
         shd   <= '0;
         SEG   <= SEG_OFF;
         DP    <= 1'b1;
         AN    <= AN_OFF;
         FRAME <= 1'b0;
      end else begin
         slot  <= slot_n;
         dig   <= dig_n;
         fcnt  <= fcnt_n;
         phase <= phase_n;
         shd   <= shd_n;
         SEG   <= seg_n;
         DP    <= dp_n;
         AN    <= an_n;
         FRAME <= frame_n;
      end
   end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed four-digit seven-segment display driver that reads the BCD digits produced by two 0–59 up/down counters (minutes and seconds) and drives a common-anode display. The counters produce the digits; this block consumes them. It snapshots all four digits once per frame, inserts anti-ghosting dead time between digits, and supports per-digit blinking and leading-zero blanking. It sits between the counter pair and the board display pins.

## Interface
- SCAN_DIV, 50000: CLK cycles per digit slot (≥ BLANK_CYC+1).
- BLANK_CYC, 16: dead-time cycles at the start of each slot (≥1).
- BLINK_DIV, 250: frames per blink half-period (≥1).

- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  synchronous, active-low reset.
- ENABLE  in  1  1 = display on; 0 = all outputs blanked, counters keep running.
- SEC10  in  4  seconds ones digit (BCD).
- SEC6  in  3  seconds tens digit.
- MIN10  in  4  minutes ones digit (BCD).
- MIN6  in  3  minutes tens digit.
- BLINK  in  4  per-digit blink enable, bit i = digit i.
- LZB  in  1  leading-zero blank for digit 3.
- SEG  out  7  active-low segments {g,f,e,d,c,b,a}.
- DP  out  1  active-low decimal point (minutes/seconds separator).
- AN  out  4  active-low digit anodes, bit i = digit i.
- FRAME  out  1  one-cycle pulse at the start of each frame.

## Operation
- Digit map: 0 = SEC10, 1 = SEC6, 2 = MIN10, 3 = MIN6. 3-bit inputs are zero-extended.
- Slot counter runs 0..SCAN_DIV-1. On wrap, the digit index advances 0→1→2→3→0. Frame = 4 slots.
- Snapshot: on the edge that starts digit-0's slot, all four inputs are latched into shadow registers. Display uses shadow values only; mid-frame input changes take effect next frame.
- Slot phases: BLANK for the first BLANK_CYC cycles (AN=1111, SEG=1111111, DP=1), then ON for the rest of the slot (AN bit of current digit low).
- Decode: 0–9 use the standard patterns. Any value >9 shows a dash, SEG=0111111.
- Blink: a frame counter runs 0..BLINK_DIV-1. The phase bit toggles when it wraps. Phase resets to 1 (visible). If BLINK[i]=1 and phase=0, digit i stays blanked for its whole slot.
- LZB=1 and shadow MIN6==0: digit 3 blanked.
- DP low during digit 2's ON phase only when phase=1; otherwise DP=1.
- ENABLE=0: AN=1111, SEG=1111111, DP=1. Slot, frame and blink counters and snapshots continue.
- Reset (RESET=0 at an edge) sets all of the following, including mid-slot:
  - slot, digit, frame counters = 0; phase = 1; shadows = 0;
  - AN=1111, SEG=1111111, DP=1, FRAME=0.

## Timing
- All outputs are registered.
- FRAME is high in the first cycle after the first edge that samples RESET=1, then every 4·SCAN_DIV cycles. Shadows load on that same edge.
- Relative to a FRAME cycle at t=0:
  - digit 0: AN=1110 for cycles BLANK_CYC..SCAN_DIV-1.
  - digit 1: AN=1101 from SCAN_DIV+BLANK_CYC to 2·SCAN_DIV-1.
  - digits 2 and 3 follow the same pattern.
- SEG and DP change only at ON-phase start and at BLANK entry; they are never glitched inside the ON phase.
- Blink phase toggles on the FRAME edge that wraps the frame counter: first toggle at frame BLINK_DIV.

## Structure
- Package seg7_pkg holds:
  - segment constants SEG_0..SEG_9, SEG_DASH (0111111), SEG_OFF (1111111);
  - AN_OFF (1111);
  - slot-phase enum {PH_BLANK, PH_ON}.
- Sub-module seg7_decode: combinational 4-bit value → 7-bit active-low pattern, dash for >9.
- Counter widths are derived with $clog2 of the parameters.

## Test plan
Parameters SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=2.
- Reset, then MIN6=2, MIN10=5, SEC6=3, SEC10=7, ENABLE=1 → per frame:
  - digit 0: AN=1110, SEG=1111000;
  - digit 1: AN=1101, SEG=0110000;
  - digit 2: AN=1011, SEG=0010010, DP=0;
  - digit 3: AN=0111, SEG=0100100.
- Timing check → FRAME every 32 cycles; AN=1111 for exactly 2 cycles at each slot start; each digit low for 6 cycles.
- Change SEC10 7→8 in digit 2's slot → digit 0 shows 1111000 for the rest of that frame, 0000000 from the next FRAME.
- MIN10=4'hC → digit 2 SEG=0111111. LZB=1, MIN6=0 → AN[3] never low. LZB=0 → digit 3 SEG=1000000.
- BLINK=0001 → AN[0] low during frames 0–1, never low in frames 2–3, low again in 4–5. DP follows the same on/off cadence.
- Assert RESET for 1 cycle mid digit-1 ON phase → next cycle AN=1111, SEG=1111111, FRAME=0. FRAME returns 1 cycle after the release edge, with fresh snapshots.
